// File: rtl/pipelined_adder.sv
// Pipelined two's-complement adder/subtractor: a WIDTH-bit carry chain split into STAGES
// registered slices under a single global-advance valid/ready handshake.
// Optional output clamping on signed overflow: define PIPELINED_ADDER_SATURATE_EN.
module pipelined_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    input  logic             in_carry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_carry,
    output logic             out_overflow
);

    localparam int CW = WIDTH / STAGES;

    if ((STAGES < 1) || (STAGES > WIDTH) || ((WIDTH % STAGES) != 0)) begin : g_param_check
        $error("pipelined_adder: WIDTH must be a multiple of STAGES and 1 <= STAGES <= WIDTH");
    end

`ifdef PIPELINED_ADDER_SATURATE_EN
    function automatic logic signed [WIDTH-1:0] sat_fn(
        input logic signed [WIDTH-1:0] s,
        input logic                    ovf,
        input logic                    a_neg
    );
        logic signed [WIDTH-1:0] lim;
        lim = a_neg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        return ovf ? lim : s;
    endfunction
`endif

    logic             adv;
    logic [WIDTH-1:0] eff_b;
    logic             eff_cin;

    // The whole pipeline moves together: it advances whenever the last stage is empty or drained.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;
    assign eff_b    = in_sub ? ~in_b : in_b;
    assign eff_cin  = in_sub ? 1'b1 : in_carry;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic             v_in;
        logic             c_in;
        logic             sa_in;
        logic             sb_in;
        logic [WIDTH-1:0] a_in;
        logic [WIDTH-1:0] b_in;
        logic [WIDTH-1:0] s_in;
        logic [WIDTH-1:0] s_nxt;
        logic [CW:0]      res;

        logic             vld_p;
        logic             cy_p;
        logic             sa_p;
        logic             sb_p;
        logic [WIDTH-1:0] a_p;
        logic [WIDTH-1:0] b_p;
        logic [WIDTH-1:0] sum_p;

        if (k == 0) begin : g_src
            assign v_in  = in_valid;
            assign c_in  = eff_cin;
            assign a_in  = in_a;
            assign b_in  = eff_b;
            assign s_in  = '0;
            assign sa_in = in_a[WIDTH-1];
            assign sb_in = eff_b[WIDTH-1];
        end else begin : g_src
            assign v_in  = g_stage[k-1].vld_p;
            assign c_in  = g_stage[k-1].cy_p;
            assign a_in  = g_stage[k-1].a_p;
            assign b_in  = g_stage[k-1].b_p;
            assign s_in  = g_stage[k-1].sum_p;
            assign sa_in = g_stage[k-1].sa_p;
            assign sb_in = g_stage[k-1].sb_p;
        end

        assign res = {1'b0, a_in[k*CW +: CW]} + {1'b0, b_in[k*CW +: CW]} + {{CW{1'b0}}, c_in};

        always_comb begin
            s_nxt               = s_in;
            s_nxt[k*CW +: CW]   = res[CW-1:0];
        end

        // ---- stage k register boundary ----
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_p <= 1'b0;
                cy_p  <= 1'b0;
                sa_p  <= 1'b0;
                sb_p  <= 1'b0;
                a_p   <= '0;
                b_p   <= '0;
                sum_p <= '0;
            end else if (adv) begin
                vld_p <= v_in;
                cy_p  <= res[CW];
                sa_p  <= sa_in;
                sb_p  <= sb_in;
                a_p   <= a_in;
                b_p   <= b_in;
                sum_p <= s_nxt;
            end
        end

        if (k == STAGES - 1) begin : g_tail
            // Operands are fully consumed by the last slice; synthesis trims these registers.
            logic unused_ops;
            assign unused_ops = ^{a_p, b_p};
        end
    end

    logic signed [WIDTH-1:0] wrap_sum_p;
    logic                    ovf_p;

    assign wrap_sum_p   = g_stage[STAGES-1].sum_p;
    assign ovf_p        = (g_stage[STAGES-1].sa_p == g_stage[STAGES-1].sb_p)
                          && (wrap_sum_p[WIDTH-1] != g_stage[STAGES-1].sa_p);
    assign out_valid    = g_stage[STAGES-1].vld_p;
    assign out_carry    = g_stage[STAGES-1].cy_p;
    assign out_overflow = ovf_p;

`ifdef PIPELINED_ADDER_SATURATE_EN
    assign out_sum = sat_fn(wrap_sum_p, ovf_p, g_stage[STAGES-1].sa_p);
`else
    assign out_sum = wrap_sum_p;
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench for pipelined_adder (defaults WIDTH=32, STAGES=4); results are predicted
// with whole-word integer arithmetic and compared by an independent output monitor.
module tb_pipelined_adder;

    localparam int W = 32;
    localparam int S = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_sub;
    logic         in_carry;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_carry;
    logic         out_overflow;

    pipelined_adder #(.WIDTH(W), .STAGES(S)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_a         (in_a),
        .in_b         (in_b),
        .in_sub       (in_sub),
        .in_carry     (in_carry),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_sum      (out_sum),
        .out_carry    (out_carry),
        .out_overflow (out_overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         carry;
        logic         ovf;
    } exp_t;

    exp_t sb[$];
    int   pass_cnt = 0;
    int   tot_cnt  = 0;
    int   rdy_mode = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        tot_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, req);
    endtask

    // Reference: exact signed/unsigned integer results, then wrapped to W bits.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic sub, input logic cin);
        exp_t     e;
        longint   sa, sbv, r;
        logic [63:0] u;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        r   = sub ? (sa - sbv) : (sa + sbv + longint'(cin));
        u   = {32'b0, a} + {32'b0, b} + {63'b0, cin};
        e.sum   = r[W-1:0];
        e.carry = sub ? (a >= b) : u[W];
        e.ovf   = (r > 64'sd2147483647) || (r < -64'sd2147483648);
`ifdef PIPELINED_ADDER_SATURATE_EN
        if (e.ovf) e.sum = (r > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
`endif
        return e;
    endfunction

    // Consumer-side handshake pattern, updated just after each rising edge.
    initial begin
        int c;
        c = 0;
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ((c % 4) == 0) || ((c % 4) == 3);
                2:       out_ready = ($urandom_range(0, 3) != 0);
                default: out_ready = 1'b0;
            endcase
            c++;
        end
    end

    // Monitor: pops the scoreboard on every output transfer, checks stall stability.
    logic         held;
    logic [W-1:0] h_sum;
    logic         h_c, h_o;
    initial held = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            held = 1'b0;
        end else begin
            check("in_ready_adv", in_ready, !out_valid || out_ready);
            if (held) begin
                check("stall_valid", out_valid, 1'b1);
                check("stall_sum", out_sum, h_sum);
                check("stall_flags", {h_c, h_o} == {out_carry, out_overflow}, 1'b1);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    tot_cnt++;
                    $display("FAIL unexpected_output: got sum %h with empty scoreboard, required none", out_sum);
                end else begin
                    e = sb.pop_front();
                    check("sum", out_sum, e.sum);
                    check("carry", out_carry, e.carry);
                    check("overflow", out_overflow, e.ovf);
                end
            end
            held  = out_valid && !out_ready;
            h_sum = out_sum;
            h_c   = out_carry;
            h_o   = out_overflow;
        end
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sub, input logic cin);
        bit acc;
        int guard;
        acc = 0;
        guard = 0;
        in_a = a; in_b = b; in_sub = sub; in_carry = cin; in_valid = 1'b1;
        while (!acc) begin
            @(negedge clk);
            acc = in_ready;
            if (acc) sb.push_back(model(a, b, sub, cin));
            @(posedge clk);
            #1;
            guard++;
            if (!acc && guard > 200) begin
                tot_cnt++;
                $display("FAIL send_timeout: in_ready low for %0d cycles, required accept", guard);
                acc = 1;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain(input string name);
        int g;
        g = 0;
        rdy_mode = 0;
        while (sb.size() != 0 && g < 200) begin
            @(posedge clk);
            #1;
            g++;
        end
        check(name, sb.size(), 0);
    endtask

    initial begin
        int n;
        logic [W-1:0] ra, rb;
        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0; in_carry = 1'b0;
        #12;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_sum", out_sum, '0);
        check("rst_out_carry", out_carry, 1'b0);
        check("rst_out_ovf", out_overflow, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Latency from acceptance to out_valid on an empty pipeline.
        send(32'h2, 32'h2, 1'b0, 1'b0);
        n = 1;
        @(negedge clk);
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("latency", n, S);
        @(posedge clk);
        #1;

        // Directed boundary operations.
        send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        send(32'h9200_0000, 32'hAB00_0000, 1'b0, 1'b0);
        send(32'h0000_0001, 32'h0000_0003, 1'b1, 1'b0);
        send(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0);
        send(32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b1);
        send(32'h0000_0005, 32'h0000_0003, 1'b1, 1'b1);
        send(32'h0000_0000, 32'h8000_0000, 1'b1, 1'b0);
        send(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
        drain("drain_directed");

        // Back-to-back stream under a 1,0,0,1 consumer pattern.
        rdy_mode = 1;
        for (int i = 0; i < 16; i++) send(32'h0, W'(i), 1'b0, 1'b0);
        drain("drain_stream");

        // Randomized operations, random gaps and random backpressure.
        rdy_mode = 2;
        for (int i = 0; i < 300; i++) begin
            ra = $urandom();
            rb = $urandom();
            if ($urandom_range(0, 7) == 0) ra = 32'hFFFF_FFFF;
            if ($urandom_range(0, 7) == 0) rb = 32'h8000_0000;
            send(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
        end
        drain("drain_random");

        // Reset with operations in flight and a stalled result at the output.
        rdy_mode = 3;
        @(posedge clk);
        #1;
        send(32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0);
        send(32'h0000_0010, 32'h0000_0001, 1'b1, 1'b0);
        send(32'h0F0F_0F0F, 32'h0101_0101, 1'b0, 1'b1);
        idle(3);
        check("pre_rst_valid", out_valid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        sb.delete();
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_out_sum", out_sum, '0);
        check("midrst_out_carry", out_carry, 1'b0);
        check("midrst_out_ovf", out_overflow, 1'b0);
        check("midrst_in_ready", in_ready, 1'b1);
        rdy_mode = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle(12);
        check("post_rst_idle", out_valid, 1'b0);

        // Pipeline still works after the reset.
        send(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
        drain("drain_post_rst");

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule

// File: doc/pipelined_adder.md
# pipelined_adder

Parametrised, pipelined two's-complement adder/subtractor. It splits a WIDTH-bit carry chain into STAGES registered slices and accepts one operation per cycle under a valid/ready handshake with full backpressure. It sits between operand producers and downstream datapath consumers wherever a wide add or subtract cannot close timing as a single ripple chain. It reports carry-out and signed overflow, and can optionally saturate.

## Interface
- WIDTH, 32, operand/result width in bits; must be divisible by STAGES.
- STAGES, 4, number of pipeline slices; slice width CW = WIDTH/STAGES; 1 ≤ STAGES ≤ WIDTH.
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- in_valid  in  1  operation present on in_* this cycle.
- in_ready  out  1  block accepts the operation this cycle.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_sub  in  1  0: A+B+in_carry; 1: A−B (computed as A+~B+1; in_carry ignored).
- in_carry  in  1  carry-in for add mode.
- out_valid  out  1  result present on out_*.
- out_ready  in  1  consumer accepts result this cycle.
- out_sum  out  WIDTH  result.
- out_carry  out  1  carry out of bit WIDTH−1; in sub mode 1 = no borrow.
- out_overflow  out  1  signed overflow of the operation.

## Operation
- Stage k (0..STAGES−1) registers: valid bit, sum slices 0..k, carry out of slice k, unprocessed upper slices of A and effective B, sign bits of A and effective B, sub flag.
- Effective B = in_sub ? ~in_b : in_b; effective carry-in = in_sub ? 1 : in_carry; inversion happens before stage 0.
- Stage k adds slice k of A and effective B with the carry from stage k−1 (stage 0 uses the effective carry-in). Lower completed slices and upper pending slices pass through unchanged.
- Final stage drives out_*: out_carry = carry out of top slice; out_overflow = (sign A == sign effB) && (sign sum != sign A).
- Global advance: adv = !out_valid || out_ready. When adv, every stage loads from its predecessor, and stage 0 loads from the inputs with valid = in_valid. When !adv, all stages hold.
- in_ready = adv (combinational from out_valid/out_ready). Bubbles are not compressed; a bubble stalls with the pipeline.
- Transfer occurs on in_valid && in_ready (input) and out_valid && out_ready (output); out_* stable while out_valid && !out_ready.

## Timing
- Latency: STAGES cycles from input transfer to out_valid, with no stalls.
- Throughput: one operation per cycle while out_ready = 1.
- Reset (rst_n low, any time, including mid-operation): all valid bits 0, all data registers 0; out_valid = 0, out_sum = 0, out_carry = 0, out_overflow = 0; in_ready = 1. In-flight operations are discarded.
- First accept is possible on the first rising edge after rst_n deasserts.
- Simultaneous output transfer and input transfer in the same cycle is legal; occupancy is unchanged.
- Wrap-around: sums modulo 2^WIDTH; carry reported in out_carry only.

## Configuration
- PIPELINED_ADDER_SATURATE_EN defined: when overflow is detected, out_sum clamps to signed max (0111…1) if A sign = 0, else signed min (1000…0). out_overflow is still asserted and out_carry is unchanged.
- Undefined: out_sum is always the wrapped result; no clamp logic is present.

## Test plan
- WIDTH=8, STAGES=2, add 0x02+0x02, carry 0 -> after 2 cycles out_sum=0x04, carry=0, overflow=0.
- WIDTH=8, STAGES=2, add 0x92+0xAB -> out_sum=0x3D, carry=1, overflow=1; with SATURATE_EN out_sum=0x80.
- WIDTH=8, STAGES=4, sub 0x01−0x03 -> out_sum=0xFE, carry=0, overflow=0; sub 0x80−0x01 -> 0x7F (0x80 saturated), carry=1, overflow=1.
- Defaults: stream 0x0000_0000+i for i=0..15, in_valid high, out_ready toggling 1,0,0,1 -> results in order, none lost or duplicated, out_* stable while stalled, in_ready tracks adv.
- Defaults: add 0xFFFF_FFFF+0x0000_0000 with in_carry=1 -> out_sum=0, carry=1, overflow=0 (carry crosses all slices).
- Defaults: assert rst_n low with 3 operations in flight -> out_valid=0 and all outputs 0 immediately; after release, no stale results emerge.
